// File: rtl/inference_sequencer_if.sv
// Stream-side signal bundle of the inference sequencer: the feature input
// stream (s_axis_*) and the classification result stream (m00_axis_*).
// The slave modport is the sequencer's view (feature sink, result source);
// the master modport is the surrounding environment's view.
interface inference_sequencer_if #(
  parameter int DATA_W = 64
);
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic              m00_axis_tvalid;
  logic              m00_axis_tready;
  logic              m00_axis_tlast;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m00_axis_tready,
    output s_axis_tready, m00_axis_tvalid, m00_axis_tlast
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m00_axis_tready,
    input  s_axis_tready, m00_axis_tvalid, m00_axis_tlast
  );
endinterface

// File: rtl/inference_sequencer.sv
// Frame-level controller for the TM inference datapath: loads PACKETS_NUM
// feature beats, strobes the clause stages, launches the class-sum adder,
// runs the classify stage for CLASSIFY_LAT cycles and hands the result out.
// All outputs are registered and derived from the next state so that they
// line up with the state they describe.
module inference_sequencer #(
  parameter int PACKETS_NUM            = 13,
  parameter int C_S00_AXIS_TDATA_WIDTH = 64,
  parameter int CLASSIFY_LAT           = 1,
  parameter int CNT_WIDTH              = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  inference_sequencer_if.slave              axis,
  output logic [C_S00_AXIS_TDATA_WIDTH-1:0] x,
  output logic [PACKETS_NUM:0]              valid,
  input  logic                              adder_done,
  output logic                              argmax_en,
  output logic                              busy,
  output logic                              protocol_err,
  output logic [CNT_WIDTH-1:0]              inference_count
);

  localparam int IDX_W = $clog2(PACKETS_NUM);
  localparam int LAT_W = (CLASSIFY_LAT > 1) ? $clog2(CLASSIFY_LAT) : 1;

  typedef enum logic [2:0] {
    ST_LOAD     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_ADD      = 3'd2,
    ST_CLASSIFY = 3'd3,
    ST_OUT      = 3'd4
  } state_t;

  state_t                            state_r;
  state_t                            state_next_s;
  logic [IDX_W-1:0]                  idx_r;
  logic [LAT_W-1:0]                  lat_cnt_r;
  logic                              last_flag_r;
  logic                              s_hs_s;
  logic                              m_hs_s;
  logic                              last_beat_s;

  logic                              s_tready_r;
  logic [C_S00_AXIS_TDATA_WIDTH-1:0] x_r;
  logic [PACKETS_NUM:0]              valid_r;
  logic                              argmax_en_r;
  logic                              m_tvalid_r;
  logic                              m_tlast_r;
  logic                              busy_r;
  logic                              protocol_err_r;
  logic [CNT_WIDTH-1:0]              inference_count_r;

  // tready/tvalid are only ever high in LOAD/OUT, so they qualify the handshakes
  assign s_hs_s      = s_tready_r & axis.s_axis_tvalid;
  assign m_hs_s      = m_tvalid_r & axis.m00_axis_tready;
  assign last_beat_s = (idx_r == IDX_W'(PACKETS_NUM - 1));

  // Next-state decode of the frame sequencer
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_LOAD: begin
        if (s_hs_s && last_beat_s) state_next_s = ST_SETTLE;
        else                       state_next_s = ST_LOAD;
      end
      ST_SETTLE: state_next_s = ST_ADD;
      ST_ADD: begin
        if (adder_done) state_next_s = ST_CLASSIFY;
        else            state_next_s = ST_ADD;
      end
      ST_CLASSIFY: begin
        if (lat_cnt_r == {LAT_W{1'b0}}) state_next_s = ST_OUT;
        else                            state_next_s = ST_CLASSIFY;
      end
      ST_OUT: begin
        if (m_hs_s) state_next_s = ST_LOAD;
        else        state_next_s = ST_OUT;
      end
      default: state_next_s = ST_LOAD;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_LOAD;
    else        state_r <= state_next_s;
  end

  // Beat index, tlast tracking, classify down-counter and captured data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r             <= {IDX_W{1'b0}};
      last_flag_r       <= 1'b0;
      lat_cnt_r         <= {LAT_W{1'b0}};
      x_r               <= {C_S00_AXIS_TDATA_WIDTH{1'b0}};
      valid_r           <= {(PACKETS_NUM + 1){1'b0}};
      protocol_err_r    <= 1'b0;
      inference_count_r <= {CNT_WIDTH{1'b0}};
    end else begin
      valid_r <= {(PACKETS_NUM + 1){1'b0}};
      if (s_hs_s) begin
        x_r            <= axis.s_axis_tdata;
        valid_r[idx_r] <= 1'b1;
        idx_r          <= last_beat_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
        // frame length is fixed by beat count; a misplaced tlast is only flagged
        if (axis.s_axis_tlast && !last_beat_s) protocol_err_r <= 1'b1;
      end else if (state_r == ST_SETTLE) begin
        valid_r[PACKETS_NUM] <= 1'b1;
      end
      if (m_hs_s)                           last_flag_r <= 1'b0;
      else if (s_hs_s && axis.s_axis_tlast) last_flag_r <= 1'b1;
      if (state_r == ST_ADD && adder_done)
        lat_cnt_r <= LAT_W'(CLASSIFY_LAT - 1);
      else if (state_r == ST_CLASSIFY && lat_cnt_r != {LAT_W{1'b0}})
        lat_cnt_r <= lat_cnt_r - LAT_W'(1);
      if (m_hs_s) inference_count_r <= inference_count_r + CNT_WIDTH'(1'b1);
    end
  end

  // Registered status/handshake outputs, decoded from the upcoming state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_tready_r  <= 1'b0;
      busy_r      <= 1'b0;
      argmax_en_r <= 1'b0;
      m_tvalid_r  <= 1'b0;
      m_tlast_r   <= 1'b0;
    end else begin
      s_tready_r  <= (state_next_s == ST_LOAD);
      busy_r      <= (state_next_s != ST_LOAD);
      argmax_en_r <= (state_next_s == ST_CLASSIFY);
      m_tvalid_r  <= (state_next_s == ST_OUT);
      m_tlast_r   <= (state_next_s == ST_OUT) && last_flag_r;
    end
  end

  assign axis.s_axis_tready   = s_tready_r;
  assign axis.m00_axis_tvalid = m_tvalid_r;
  assign axis.m00_axis_tlast  = m_tlast_r;
  assign x                    = x_r;
  assign valid                = valid_r;
  assign argmax_en            = argmax_en_r;
  assign busy                 = busy_r;
  assign protocol_err         = protocol_err_r;
  assign inference_count      = inference_count_r;

endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: a schedule-based model predicts every output
// each cycle from the accepted beats, adder completion and result handshakes;
// directed frames exercise gaps, adder/result stalls, tlast handling and reset.
module tb_inference_sequencer;
  localparam int P  = 13;
  localparam int DW = 64;
  localparam int L  = 1;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] x;
  logic [P:0]    valid;
  logic          adder_done;
  logic          argmax_en;
  logic          busy;
  logic          protocol_err;
  logic [CW-1:0] inference_count;

  always #5 clk = ~clk;

  inference_sequencer_if #(.DATA_W(DW)) bus ();

  inference_sequencer #(
    .PACKETS_NUM(P), .C_S00_AXIS_TDATA_WIDTH(DW), .CLASSIFY_LAT(L), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .axis(bus.slave), .x(x), .valid(valid),
    .adder_done(adder_done), .argmax_en(argmax_en), .busy(busy),
    .protocol_err(protocol_err), .inference_count(inference_count)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endfunction

  // ---------------- behavioural model (schedule of expected events) --------
  bit            accepting, pending_ready, busy_f, waiting, out_armed, lastf, err;
  int            beat_idx, add_from, cls_from, cls_to, out_from, hs0;
  logic [CW-1:0] m_count;
  logic [DW-1:0] exp_x;
  int            vsched[int];
  // observation of the DUT for the literal pins
  int            first_tv, first_am, first_vbit, strobes;
  logic          tlast_at_tv;

  function automatic void model_reset();
    accepting = 0; pending_ready = 1; busy_f = 0; waiting = 0; out_armed = 0;
    lastf = 0; err = 0; beat_idx = 0; m_count = '0; exp_x = '0;
    vsched.delete();
  endfunction

  function automatic void reset_mon();
    first_tv = -1; first_am = -1; first_vbit = -1; strobes = 0; tlast_at_tv = 1'b0;
  endfunction

  function automatic void compare();
    logic [P:0] ev;
    logic       etv;
    ev = '0;
    if (rst_n && vsched.exists(cyc)) ev[vsched[cyc]] = 1'b1;
    etv = rst_n && out_armed && (cyc >= out_from);
    check("s_tready", {63'd0, bus.s_axis_tready}, {63'd0, rst_n && accepting});
    check("busy", {63'd0, busy}, {63'd0, rst_n && busy_f});
    check("valid", {50'd0, valid}, {50'd0, ev});
    check("x", x, rst_n ? exp_x : 64'd0);
    check("argmax_en", {63'd0, argmax_en},
          {63'd0, rst_n && out_armed && cyc >= cls_from && cyc <= cls_to});
    check("m_tvalid", {63'd0, bus.m00_axis_tvalid}, {63'd0, etv});
    check("m_tlast", {63'd0, bus.m00_axis_tlast}, {63'd0, etv && lastf});
    check("protocol_err", {63'd0, protocol_err}, {63'd0, rst_n && err});
    check("count", {32'd0, inference_count}, rst_n ? {32'd0, m_count} : 64'd0);
    if (bus.m00_axis_tvalid && first_tv < 0) begin
      first_tv = cyc; tlast_at_tv = bus.m00_axis_tlast;
    end
    if (argmax_en && first_am < 0) first_am = cyc;
    for (int i = 0; i < P; i++) begin
      if (valid[i]) begin
        strobes++;
        if (first_vbit < 0) first_vbit = i;
      end
    end
  endfunction

  function automatic void update();
    int c;
    c = cyc;
    if (!rst_n) begin
      model_reset();
    end else if (pending_ready) begin
      pending_ready = 0; accepting = 1;
    end else begin
      if (accepting && bus.s_axis_tvalid) begin
        exp_x = bus.s_axis_tdata;
        vsched[c + 1] = beat_idx;
        if (beat_idx == 0) hs0 = c;
        if (bus.s_axis_tlast) begin
          lastf = 1;
          if (beat_idx != P - 1) err = 1;
        end
        if (beat_idx == P - 1) begin
          beat_idx = 0; accepting = 0; busy_f = 1; waiting = 1;
          vsched[c + 2] = P; add_from = c + 2;
        end else begin
          beat_idx++;
        end
      end
      if (waiting && c >= add_from && adder_done) begin
        waiting = 0; out_armed = 1;
        cls_from = c + 1; cls_to = c + L; out_from = c + L + 1;
      end else if (out_armed && c >= out_from && bus.m00_axis_tready) begin
        out_armed = 0; m_count = m_count + 32'd1; lastf = 0; busy_f = 0; accepting = 1;
      end
    end
  endfunction

  // Per-cycle compare at the falling edge, model advance at the rising edge
  initial begin : model_proc
    model_reset();
    reset_mon();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      compare();
      @(posedge clk);
      update();
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_frame(input int gap, input int tlast_beat, input int nbeats);
    int  w;
    bit  got;
    for (int k = 0; k < nbeats; k++) begin
      bus.s_axis_tdata  = 64'(k);
      bus.s_axis_tlast  = (k == tlast_beat);
      bus.s_axis_tvalid = 1'b1;
      w = 0; got = 0;
      while (!got && w < 200) begin
        @(negedge clk);
        if (bus.s_axis_tready) got = 1;
        @(posedge clk); #1;
        w++;
      end
      if (!got) check("beat_timeout", 64'd0, 64'd1);
      bus.s_axis_tvalid = 1'b0;
      bus.s_axis_tlast  = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_count(input logic [CW-1:0] target);
    int w;
    w = 0;
    while (m_count != target && w < 300) begin
      @(posedge clk); #1;
      w++;
    end
    if (m_count != target) check("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_cycle(input int target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin : stim
    bus.s_axis_tdata = '0; bus.s_axis_tvalid = 1'b0; bus.s_axis_tlast = 1'b0;
    bus.m00_axis_tready = 1'b0; adder_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // back-to-back frame, adder done immediately, result taken at once
    adder_done = 1'b1; bus.m00_axis_tready = 1'b1;
    reset_mon();
    send_frame(0, -1, P);
    wait_count(32'd1);
    check("t1_argmax_cyc", 64'(first_am - hs0), 64'd15);
    check("t1_tvalid_cyc", 64'(first_tv - hs0), 64'd16);
    check("t1_strobes", 64'(strobes), 64'd13);
    check("t1_count", {32'd0, inference_count}, 64'd1);

    // one-cycle gaps between beats
    reset_mon();
    send_frame(1, -1, P);
    wait_count(32'd2);
    check("t2_strobes", 64'(strobes), 64'd13);
    check("t2_tvalid_cyc", 64'(first_tv - hs0), 64'd28);

    // late adder completion, stalled result, upstream pushing while busy
    adder_done = 1'b0; bus.m00_axis_tready = 1'b0;
    reset_mon();
    send_frame(0, -1, P);
    bus.s_axis_tdata = 64'hDEAD_BEEF; bus.s_axis_tvalid = 1'b1;
    wait_cycle(hs0 + 40);
    adder_done = 1'b1;
    @(posedge clk); #1 adder_done = 1'b0;
    wait_cycle(hs0 + 46);
    bus.s_axis_tvalid = 1'b0;
    wait_cycle(hs0 + 47);
    bus.m00_axis_tready = 1'b1;
    wait_count(32'd3);
    check("t3_argmax_cyc", 64'(first_am - hs0), 64'd41);
    check("t3_tvalid_cyc", 64'(first_tv - hs0), 64'd42);
    adder_done = 1'b1;

    // tlast on the final beat, then a frame without it
    reset_mon();
    send_frame(0, 12, P);
    wait_count(32'd4);
    check("t4_tlast_on", {63'd0, tlast_at_tv}, 64'd1);
    reset_mon();
    send_frame(0, -1, P);
    wait_count(32'd5);
    check("t4_tlast_off", {63'd0, tlast_at_tv}, 64'd0);

    // misplaced tlast: sticky error, frame still 13 beats long
    reset_mon();
    send_frame(0, 5, P);
    wait_count(32'd6);
    check("t5_err", {63'd0, protocol_err}, 64'd1);
    check("t5_tvalid_cyc", 64'(first_tv - hs0), 64'd16);
    send_frame(0, -1, P);
    wait_count(32'd7);
    check("t5_err_sticky", {63'd0, protocol_err}, 64'd1);

    // reset in the middle of a frame
    send_frame(0, -1, 7);
    rst_n = 1'b0;
    #1;
    check("rst_valid", {50'd0, valid}, 64'd0);
    check("rst_tready", {63'd0, bus.s_axis_tready}, 64'd0);
    check("rst_x", x, 64'd0);
    check("rst_count", {32'd0, inference_count}, 64'd0);
    check("rst_err", {63'd0, protocol_err}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    reset_mon();
    send_frame(0, -1, P);
    wait_count(32'd1);
    check("t6_first_strobe", 64'(first_vbit), 64'd0);
    check("t6_tvalid_cyc", 64'(first_tv - hs0), 64'd16);
    check("t6_count", {32'd0, inference_count}, 64'd1);
    repeat (2) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule

// File: doc/inference_sequencer.md
# inference_sequencer

Frame-level controller for the hard-coded TM inference datapath. Accepts one frame of PACKETS_NUM feature beats from the slave AXI-Stream and strobes the per-packet clause-stage valids. It then launches the class-sum adder, waits for adder completion, enables the argmax/classify stage, and presents the result on the master AXI-Stream with tlast propagation. It replaces the free-running flag logic around the clause pipeline with an explicit, resettable state machine.

## Interface
- PACKETS_NUM, 13, feature beats per inference frame (≥2)
- C_S00_AXIS_TDATA_WIDTH, 64, slave data width
- CLASSIFY_LAT, 1, cycles argmax_en is held high (≥1)
- CNT_WIDTH, 32, width of inference_count
- Clocking: one clock; reset is asynchronous and active-low.
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  feature beat
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  frame-last marker
- s_axis_tready  out  1  registered; high only in LOAD
- x  out  C_S00_AXIS_TDATA_WIDTH  registered copy of last accepted beat
- valid  out  PACKETS_NUM+1  bit k (k<PACKETS_NUM): one-cycle strobe, packet k in x; bit PACKETS_NUM: one-cycle adder start
- adder_done  in  1  class-sum adder finished (level, sampled only in ADD)
- argmax_en  out  1  classify enable
- m00_axis_tvalid  out  1  result valid
- m00_axis_tready  in  1  downstream ready
- m00_axis_tlast  out  1  frame carried tlast
- busy  out  1  state ≠ LOAD
- protocol_err  out  1  sticky: tlast seen on beat other than PACKETS_NUM-1
- inference_count  out  CNT_WIDTH  completed result handshakes, wraps

## Operation
- States: LOAD, SETTLE, ADD, CLASSIFY, OUT.
- LOAD:
  - s_axis_tready=1.
  - Each handshake (tvalid&tready) captures tdata into x and sets valid[idx] next cycle; idx increments.
  - tlast on any beat sets last_flag.
  - tlast with idx≠PACKETS_NUM-1 sets protocol_err. The frame still completes on beat count; tlast does not end the frame.
  - Handshake with idx=PACKETS_NUM-1: idx←0, go SETTLE, tready←0.
- SETTLE: one cycle; valid[PACKETS_NUM-1] is high this cycle. Go ADD; valid[PACKETS_NUM]=1 for the first ADD cycle.
- ADD: wait for adder_done=1 (sampled in any ADD cycle, including the first). Then go CLASSIFY; adder_done outside ADD is ignored.
- CLASSIFY: argmax_en=1 for exactly CLASSIFY_LAT cycles (down-counter), then go OUT.
- OUT:
  - m00_axis_tvalid=1; m00_axis_tlast=last_flag.
  - Both are held stable until m00_axis_tready=1.
  - On the handshake: last_flag←0, inference_count+1 (mod 2^CNT_WIDTH), go LOAD, tready←1 next cycle.
- At most one bit of valid is high in any cycle. valid is all-zero outside strobes.
- protocol_err is cleared only by reset.

## Timing
- Reset (async assert): state LOAD, all outputs 0 (s_axis_tready, x, valid, argmax_en, m00_axis_tvalid/tlast, busy, protocol_err, inference_count), idx=0, last_flag=0.
- s_axis_tready rises on the first clk edge after rst_n deasserts.
- Reset mid-frame abandons the frame; no valid strobe or result is produced for it.
- Back-to-back beats accepted at cycles 0..P-1 (P=PACKETS_NUM):
  - valid[k] is high at cycle k+1.
  - busy=1 from cycle P.
  - valid[P] is high at cycle P+1.
- adder_done first high at cycle t≥P+1: argmax_en is high for cycles t+1..t+CLASSIFY_LAT, and m00_axis_tvalid rises at t+CLASSIFY_LAT+1.
- Result handshake at cycle r: m00_axis_tvalid low at r+1, s_axis_tready high at r+1, busy low at r+1.
- s_axis_tvalid gaps in LOAD stall idx with no strobe. Upstream data in non-LOAD states is not accepted (tready=0).
- Minimum frame period, with adder_done immediate and tready=1: P+CLASSIFY_LAT+3 cycles.

## Test plan
- Reset then 13 back-to-back beats (tdata=k), adder_done held 1, m00_axis_tready=1, CLASSIFY_LAT=1:
  - valid[k] at cycles 1..13 with x=k.
  - valid[13] at 14, argmax_en at 15, m00_axis_tvalid at 16 and low at 17.
  - inference_count=1.
- tvalid toggled every other cycle: 13 strobes in order, none doubled. SETTLE is entered only after beat 12.
- adder_done delayed to cycle 40; m00_axis_tready held 0 for 5 cycles:
  - argmax_en only at 41.
  - m00_axis_tvalid stable from 42 to the handshake.
  - No s_axis_tready until after the handshake.
- tlast on beat 12: m00_axis_tlast=1 with the result. The next frame without tlast gives m00_axis_tlast=0.
- tlast on beat 5: protocol_err=1, stays 1 across frames, and the frame still completes after 13 beats.
- rst_n low at cycle 7 mid-frame: all outputs 0 immediately. After release, a fresh 13-beat frame completes with valid[0] as the first strobe.
